// File: rtl/vga_timing_gen_if.sv
// Pixel request bus between the VGA timing generator (master) and the upstream frame
// source (slave): coordinates go out, RGB comes back one cycle later.
interface vga_timing_gen_if;
  logic        pix_req;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic        frame_start;
  logic [23:0] rgb_in;

  modport master (
    output pix_req,
    output pix_x,
    output pix_y,
    output frame_start,
    input  rgb_in
  );

  modport slave (
    input  pix_req,
    input  pix_x,
    input  pix_y,
    input  frame_start,
    output rgb_in
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: lock-filtered start-up, h/v counters, and a two-stage
// pipeline so that sync, blank and RGB reach the DAC two cycles after the pixel request.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE  = 1280,
  parameter int unsigned H_FP      = 48,
  parameter int unsigned H_SYNC    = 112,
  parameter int unsigned H_BP      = 248,
  parameter int unsigned V_ACTIVE  = 1024,
  parameter int unsigned V_FP      = 1,
  parameter int unsigned V_SYNC    = 3,
  parameter int unsigned V_BP      = 38,
  parameter bit          HS_POL    = 1'b1,
  parameter bit          VS_POL    = 1'b1,
  parameter int unsigned LOCK_FILT = 16
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             enable,
  vga_timing_gen_if.master pix_bus,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_blank_n,
  output logic [23:0]      vga_rgb,
  output logic             running
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned LockW   = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;

  localparam logic [10:0] HLast     = 11'(H_TOTAL - 1);
  localparam logic [10:0] VLast     = 11'(V_TOTAL - 1);
  localparam logic [10:0] HActEnd   = 11'(H_ACTIVE);
  localparam logic [10:0] VActEnd   = 11'(V_ACTIVE);
  localparam logic [10:0] HSyncBeg  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HSyncEnd  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VSyncBeg  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VSyncEnd  = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [LockW-1:0] LockLast = LockW'(LOCK_FILT - 1);

  typedef enum logic [1:0] {StIdle, StWaitLock, StRun} state_e;

  state_e             state_q, state_d;
  logic               lock_meta_q, lock_s_q;
  logic [LockW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [10:0]        h_q, h_d, v_q, v_d;

  // Stage 0: registered request outputs plus syncs aligned with them
  logic               pix_req_q, pix_req_d;
  logic [10:0]        pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic               frame_start_q, frame_start_d;
  logic               hs0_q, hs0_d, vs0_q, vs0_d;
  // Stage 1 and DAC stage
  logic               act1_q, hs1_q, vs1_q;
  logic               vga_hs_q, vga_hs_d, vga_vs_q, vga_vs_d;
  logic               blank_n_q;
  logic [23:0]        rgb_q, rgb_d;

  logic               run_ok, active, frame_end;

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = '0;
    h_d        = '0;
    v_d        = '0;
    frame_end  = (h_q == HLast) && (v_q == VLast);
    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StWaitLock;
      end
      StWaitLock: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (lock_s_q) begin
          if (lock_cnt_q == LockLast) begin
            state_d = StRun;
          end else begin
            lock_cnt_d = lock_cnt_q + LockW'(1);
          end
        end
      end
      StRun: begin
        // Lock loss abandons the frame anywhere; enable is only honoured at frame end
        if (!lock_s_q || (frame_end && !enable)) begin
          state_d = StIdle;
        end else if (h_q == HLast) begin
          v_d = (v_q == VLast) ? 11'd0 : v_q + 11'd1;
        end else begin
          h_d = h_q + 11'd1;
          v_d = v_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Gating with the synchronised lock drops requests in the same cycle lock loss is seen
  always_comb begin
    run_ok        = (state_q == StRun) && lock_s_q;
    active        = run_ok && (h_q < HActEnd) && (v_q < VActEnd);
    pix_req_d     = active;
    pix_x_d       = active ? h_q : 11'd0;
    pix_y_d       = active ? v_q : 11'd0;
    frame_start_d = run_ok && (h_q == 11'd0) && (v_q == 11'd0);
    hs0_d         = run_ok && (h_q >= HSyncBeg) && (h_q < HSyncEnd);
    vs0_d         = run_ok && (v_q >= VSyncBeg) && (v_q < VSyncEnd);
    vga_hs_d      = hs1_q ? HS_POL : ~HS_POL;
    vga_vs_d      = vs1_q ? VS_POL : ~VS_POL;
    rgb_d         = act1_q ? pix_bus.rgb_in : 24'd0;
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      lock_meta_q   <= 1'b0;
      lock_s_q      <= 1'b0;
      lock_cnt_q    <= '0;
      h_q           <= '0;
      v_q           <= '0;
      pix_req_q     <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      frame_start_q <= 1'b0;
      hs0_q         <= 1'b0;
      vs0_q         <= 1'b0;
      act1_q        <= 1'b0;
      hs1_q         <= 1'b0;
      vs1_q         <= 1'b0;
      vga_hs_q      <= ~HS_POL;
      vga_vs_q      <= ~VS_POL;
      blank_n_q     <= 1'b0;
      rgb_q         <= '0;
    end else begin
      state_q       <= state_d;
      lock_meta_q   <= pll_locked;
      lock_s_q      <= lock_meta_q;
      lock_cnt_q    <= lock_cnt_d;
      h_q           <= h_d;
      v_q           <= v_d;
      pix_req_q     <= pix_req_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      frame_start_q <= frame_start_d;
      hs0_q         <= hs0_d;
      vs0_q         <= vs0_d;
      act1_q        <= pix_req_q;
      hs1_q         <= hs0_q;
      vs1_q         <= vs0_q;
      vga_hs_q      <= vga_hs_d;
      vga_vs_q      <= vga_vs_d;
      blank_n_q     <= act1_q;
      rgb_q         <= rgb_d;
    end
  end

  assign pix_bus.pix_req     = pix_req_q;
  assign pix_bus.pix_x       = pix_x_q;
  assign pix_bus.pix_y       = pix_y_q;
  assign pix_bus.frame_start = frame_start_q;
  assign vga_hs              = vga_hs_q;
  assign vga_vs              = vga_vs_q;
  assign vga_blank_n         = blank_n_q;
  assign vga_rgb             = rgb_q;
  assign running             = (state_q == StRun);

endmodule
